// File: rtl/shift_barrel_pkg.sv
// Shared op encoding and stage-partition helper for the pipelined barrel shifter.
package shift_barrel_pkg;

    typedef logic [1:0] shop_t;

    localparam shop_t SHOP_SLL = 2'd0;
    localparam shop_t SHOP_SRL = 2'd1;
    localparam shop_t SHOP_SRA = 2'd2;
    localparam shop_t SHOP_ROL = 2'd3;

    // Stage s owns mux levels [stage_first_level(s), stage_first_level(s+1)).
    function automatic int unsigned stage_first_level(input int unsigned stage,
                                                      input int unsigned levels,
                                                      input int unsigned stages);
        return (stage * levels) / stages;
    endfunction

endpackage

// File: rtl/shift_barrel_level.sv
// One combinational mux level: shifts/rotates by Amount when enabled.
// With SHIFT_BARREL_PIPE_STICKY_EN it also reports whether this level dropped any set bit.
module shift_barrel_level
    import shift_barrel_pkg::*;
#(
    parameter int unsigned Bits   = 64,
    parameter int unsigned Amount = 1
) (
    input  logic [Bits-1:0] data_i,
    input  shop_t           op_i,
    input  logic            en_i,
    output logic [Bits-1:0] data_o
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    ,
    output logic            sticky_o
`endif
);

    logic [Bits-1:0] shifted;

    always_comb begin
        shifted = data_i;
        case (op_i)
            SHOP_SLL: shifted = data_i << Amount;
            SHOP_SRL: shifted = data_i >> Amount;
            SHOP_SRA: shifted = $unsigned($signed(data_i) >>> Amount);
            default:  shifted = {data_i[Bits-Amount-1:0], data_i[Bits-1:Bits-Amount]};
        endcase
    end

    assign data_o = en_i ? shifted : data_i;

`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    always_comb begin
        sticky_o = 1'b0;
        if (en_i) begin
            case (op_i)
                SHOP_SLL:           sticky_o = |data_i[Bits-1 -: Amount];
                SHOP_SRL, SHOP_SRA: sticky_o = |data_i[Amount-1:0];
                default:            sticky_o = 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/shift_barrel_pipe.sv
// Pipelined SLL/SRL/SRA/ROL barrel shifter with valid/retry handshake and tag passthrough.
// Defining SHIFT_BARREL_PIPE_STICKY_EN adds outSticky (OR of all bits shifted off the end).
module shift_barrel_pipe
    import shift_barrel_pkg::*;
#(
    parameter int unsigned Bits    = 64,
    parameter int unsigned Stages  = 2,
    parameter int unsigned TagBits = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    output logic                    inRetry,
    input  logic [Bits-1:0]         inData,
    input  logic [$clog2(Bits)-1:0] inSh,
    input  logic [1:0]              inOp,
    input  logic [TagBits-1:0]      inTag,
    output logic                    outValid,
    input  logic                    outRetry,
    output logic [Bits-1:0]         outData,
    output logic [TagBits-1:0]      outTag
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    ,
    output logic                    outSticky
`endif
);

    localparam int unsigned Levels = $clog2(Bits);

    logic [Stages-1:0]  valid_q;
    logic [Bits-1:0]    data_q   [Stages];
    logic [Levels-1:0]  sh_q     [Stages];
    shop_t              op_q     [Stages];
    logic [TagBits-1:0] tag_q    [Stages];

    logic [Stages-1:0]  src_valid;
    logic [Bits-1:0]    src_data [Stages];
    logic [Levels-1:0]  src_sh   [Stages];
    shop_t              src_op   [Stages];
    logic [TagBits-1:0] src_tag  [Stages];
    logic [Bits-1:0]    nxt_data [Stages];
    logic [Stages-1:0]  ready;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    logic [Stages-1:0]  sticky_q;
    logic [Stages-1:0]  src_sticky;
    logic [Stages-1:0]  nxt_sticky;
`endif

    // A stage loads when it is empty or every stage below it is full and draining.
    always_comb begin : ready_chain
        logic drain;
        drain = !outRetry;
        for (int s = Stages - 1; s >= 0; s--) begin
            drain    = drain || !valid_q[s];
            ready[s] = drain;
        end
    end

    assign inRetry = !ready[0];

    for (genvar s = 0; s < Stages; s++) begin : g_stage
        localparam int unsigned Lo = stage_first_level(s, Levels, Stages);
        localparam int unsigned Hi = stage_first_level(s + 1, Levels, Stages);

        if (s == 0) begin : g_src_port
            assign src_valid[s] = inValid;
            assign src_data[s]  = inData;
            assign src_sh[s]    = inSh;
            assign src_op[s]    = inOp;
            assign src_tag[s]   = inTag;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
            assign src_sticky[s] = 1'b0;
`endif
        end else begin : g_src_reg
            assign src_valid[s] = valid_q[s-1];
            assign src_data[s]  = data_q[s-1];
            assign src_sh[s]    = sh_q[s-1];
            assign src_op[s]    = op_q[s-1];
            assign src_tag[s]   = tag_q[s-1];
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
            assign src_sticky[s] = sticky_q[s-1];
`endif
        end

        for (genvar k = Lo; k < Hi; k++) begin : g_level
            logic [Bits-1:0] lvl_in;
            logic [Bits-1:0] lvl_out;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
            logic            lvl_sticky_in;
            logic            lvl_sticky;
            logic            lvl_sticky_out;
`endif
            if (k == Lo) begin : g_first
                assign lvl_in = src_data[s];
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
                assign lvl_sticky_in = src_sticky[s];
`endif
            end else begin : g_next
                assign lvl_in = g_level[k-1].lvl_out;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
                assign lvl_sticky_in = g_level[k-1].lvl_sticky_out;
`endif
            end

            shift_barrel_level #(
                .Bits  (Bits),
                .Amount(2 ** k)
            ) u_level (
                .data_i  (lvl_in),
                .op_i    (src_op[s]),
                .en_i    (src_sh[s][k]),
                .data_o  (lvl_out)
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
                ,
                .sticky_o(lvl_sticky)
`endif
            );
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
            assign lvl_sticky_out = lvl_sticky_in | lvl_sticky;
`endif
        end

        assign nxt_data[s] = g_level[Hi-1].lvl_out;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
        assign nxt_sticky[s] = g_level[Hi-1].lvl_sticky_out;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < Stages; s++) begin
                data_q[s] <= '0;
                sh_q[s]   <= '0;
                op_q[s]   <= SHOP_SLL;
                tag_q[s]  <= '0;
            end
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
            sticky_q <= '0;
`endif
        end else begin
            for (int s = 0; s < Stages; s++) begin
                if (ready[s]) begin
                    valid_q[s] <= src_valid[s];
                    if (src_valid[s]) begin
                        data_q[s] <= nxt_data[s];
                        sh_q[s]   <= src_sh[s];
                        op_q[s]   <= src_op[s];
                        tag_q[s]  <= src_tag[s];
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
                        sticky_q[s] <= nxt_sticky[s];
`endif
                    end
                end
            end
        end
    end

    assign outValid = valid_q[Stages-1];
    assign outData  = data_q[Stages-1];
    assign outTag   = tag_q[Stages-1];
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    assign outSticky = sticky_q[Stages-1];
`endif

endmodule

// File: tb/tb_shift_barrel_pipe.sv
// Bench for shift_barrel_pipe at Bits=8, Stages=3: directed vectors checked against a queue model.
`timescale 1ns/1ps
module tb_shift_barrel_pipe;

    localparam int Bits    = 8;
    localparam int Stages  = 3;
    localparam int TagBits = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               inValid;
    logic               inRetry;
    logic [Bits-1:0]    inData;
    logic [2:0]         inSh;
    logic [1:0]         inOp;
    logic [TagBits-1:0] inTag;
    logic               outValid;
    logic               outRetry;
    logic [Bits-1:0]    outData;
    logic [TagBits-1:0] outTag;
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
    logic               outSticky;
`endif

    shift_barrel_pipe #(
        .Bits   (Bits),
        .Stages (Stages),
        .TagBits(TagBits)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .inValid (inValid),
        .inRetry (inRetry),
        .inData  (inData),
        .inSh    (inSh),
        .inOp    (inOp),
        .inTag   (inTag),
        .outValid(outValid),
        .outRetry(outRetry),
        .outData (outData),
        .outTag  (outTag)
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
        ,
        .outSticky(outSticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sticky;
        logic [3:0] tag;
        int         acc;
        bit         lat_ok;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         out_cnt = 0;
    int         run_len = 0;
    int         last_xfer_cyc = -10;
    bit         no_stall = 1'b1;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [3:0] prev_tag;
    logic [7:0] last_data;
    logic [3:0] last_tag;
    logic       last_sticky;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference result built on double-width words instead of mux levels.
    function automatic logic [7:0] model_data(input logic [7:0] d, input int sh, input int op);
        logic [15:0] w;
        case (op)
            0:       begin w = {8'h00, d} << sh;      return w[7:0];  end
            1:       begin w = {d, 8'h00} >> sh;      return w[15:8]; end
            2:       begin w = {{8{d[7]}}, d} >> sh;  return w[7:0];  end
            default: begin w = {d, d} << sh;          return w[15:8]; end
        endcase
    endfunction

    function automatic logic model_sticky(input logic [7:0] d, input int sh, input int op);
        logic [15:0] w;
        case (op)
            0:       begin w = {8'h00, d} << sh; return |w[15:8]; end
            1, 2:    begin w = {d, 8'h00} >> sh; return |w[7:0];  end
            default: return 1'b0;
        endcase
    endfunction

    // Compare process: every output transfer, every held-stall cycle, every accept.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check(outValid == 1'b1, "hold_valid", outValid, 1);
                check(outData == prev_data, "hold_data", outData, prev_data);
                check(outTag == prev_tag, "hold_tag", outTag, prev_tag);
            end
            if (outValid && !outRetry) begin
                if (q.size() == 0) begin
                    check(1'b0, "spurious_output", outData, 0);
                end else begin
                    e = q.pop_front();
                    check(outData == e.data, "out_data", outData, e.data);
                    check(outTag == e.tag, "out_tag", outTag, e.tag);
                    if (e.lat_ok) check(cyc - e.acc == Stages, "latency", cyc - e.acc, Stages);
`ifdef SHIFT_BARREL_PIPE_STICKY_EN
                    check(outSticky == e.sticky, "out_sticky", outSticky, e.sticky);
                    last_sticky = outSticky;
`endif
                    last_data = outData;
                    last_tag  = outTag;
                    out_cnt++;
                    run_len = (last_xfer_cyc == cyc - 1) ? run_len + 1 : 1;
                    last_xfer_cyc = cyc;
                end
            end
            prev_stall = outValid && outRetry;
            prev_data  = outData;
            prev_tag   = outTag;
            if (inValid && !inRetry) begin
                e.data   = model_data(inData, int'(inSh), int'(inOp));
                e.sticky = model_sticky(inData, int'(inSh), int'(inOp));
                e.tag    = inTag;
                e.acc    = cyc;
                e.lat_ok = no_stall;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [7:0] d, input int sh, input int op, input int tag);
        int n;
        n = 0;
        inValid = 1'b1;
        inData  = d;
        inSh    = 3'(sh);
        inOp    = 2'(op);
        inTag   = 4'(tag);
        @(negedge clk);
        while (inRetry && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check(1'b0, "send_timeout", n, 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic wait_out(input int k);
        int target;
        int n;
        target = out_cnt + k;
        n = 0;
        while (out_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (out_cnt < target) check(1'b0, "wait_out_timeout", out_cnt, target);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(q.size() == 0, "drain", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_exp [4];
        logic [7:0] stall_data [4];
        int acc;
        bit accepted;
        t1_exp = '{8'hA8, 8'h16, 8'hF6, 8'hAD};
        stall_data = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset = 1'b1; inValid = 1'b0; outRetry = 1'b0;
        inData = '0; inSh = '0; inOp = '0; inTag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(outValid == 1'b0, "reset_outvalid", outValid, 0);
        check(outData == 8'h00, "reset_outdata", outData, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check(inRetry == 1'b0, "inretry_after_reset", inRetry, 0);
        @(posedge clk);
        #1;

        // Four ops on 0xB5 by 3.
        for (int op = 0; op < 4; op++) begin
            send(8'hB5, 3, op, op);
            wait_out(1);
            check(last_data == t1_exp[op], "b5_sh3", last_data, t1_exp[op]);
            check(last_tag == 4'(op), "b5_tag", last_tag, op);
        end

        // Edge amounts.
        for (int op = 0; op < 4; op++) begin
            send(8'h5A, 0, op, 4 + op);
            wait_out(1);
            check(last_data == 8'h5A, "sh0", last_data, 8'h5A);
        end
        send(8'h80, 7, 2, 9);
        wait_out(1);
        check(last_data == 8'hFF, "sra_80_7", last_data, 8'hFF);
        send(8'h81, 7, 3, 10);
        wait_out(1);
        check(last_data == 8'hC0, "rol_81_7", last_data, 8'hC0);

        // Back-to-back random stream.
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), i);
        end
        wait_drain();
        check(run_len == 16, "stream_consecutive", run_len, 16);

        // Stall: exactly Stages accepted, then release.
        no_stall = 1'b0;
        outRetry = 1'b1;
        acc = 0;
        inValid = 1'b1; inData = stall_data[0]; inSh = 3'd1; inOp = 2'd1; inTag = 4'd8;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            accepted = !inRetry;
            @(posedge clk);
            #1;
            if (accepted) begin
                acc++;
                inData = stall_data[acc];
                inTag  = 4'(8 + acc);
            end
        end
        check(acc == Stages, "stall_accepts", acc, Stages);
        @(negedge clk);
        check(inRetry == 1'b1, "stall_inretry", inRetry, 1);
        @(posedge clk);
        #1;
        outRetry = 1'b0;
        @(negedge clk);
        check(inRetry == 1'b0, "release_inretry", inRetry, 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        wait_drain();
        no_stall = 1'b1;

        // Reset with two requests in flight.
        send(8'hF0, 1, 0, 1);
        send(8'h0F, 2, 1, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check(outValid == 1'b0, "reset_flush", outValid, 0);
        check(inRetry == 1'b0, "reset_flush_inretry", inRetry, 0);
        repeat (6) @(posedge clk);
        #1;
        send(8'h01, 7, 0, 3);
        wait_out(1);
        check(last_data == 8'h80, "post_reset_sll", last_data, 8'h80);

`ifdef SHIFT_BARREL_PIPE_STICKY_EN
        send(8'h05, 2, 1, 4);
        wait_out(1);
        check(last_data == 8'h01, "sticky_srl5_data", last_data, 8'h01);
        check(last_sticky == 1'b1, "sticky_srl5", last_sticky, 1);
        send(8'h04, 2, 1, 5);
        wait_out(1);
        check(last_data == 8'h01, "sticky_srl4_data", last_data, 8'h01);
        check(last_sticky == 1'b0, "sticky_srl4", last_sticky, 0);
        send(8'h40, 2, 0, 6);
        wait_out(1);
        check(last_sticky == 1'b1, "sticky_sll40", last_sticky, 1);
`endif

        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
